// File: rtl/conv_sched_pkg.sv
// Shared definitions for the layer scheduler: FSM state encoding and the
// descriptor word layout {map_size, out_ch, in_ch}.
package conv_sched_pkg;

  localparam int ST_IDLE  = 0;
  localparam int ST_LOAD  = 1;
  localparam int ST_START = 2;
  localparam int ST_RUN   = 3;
  localparam int ST_DONE  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'(ST_IDLE),
    LOAD  = 3'(ST_LOAD),
    START = 3'(ST_START),
    RUN   = 3'(ST_RUN),
    DONE  = 3'(ST_DONE)
  } sched_state_t;

  localparam int DESC_W     = 32;
  localparam int CH_W       = 8;
  localparam int MAP_W      = 16;
  localparam int IN_CH_LSB  = 0;
  localparam int OUT_CH_LSB = 8;
  localparam int MAP_LSB    = 16;

  function automatic logic [CH_W-1:0] desc_in_ch(input logic [DESC_W-1:0] d);
    return d[IN_CH_LSB +: CH_W];
  endfunction

  function automatic logic [CH_W-1:0] desc_out_ch(input logic [DESC_W-1:0] d);
    return d[OUT_CH_LSB +: CH_W];
  endfunction

  function automatic logic [MAP_W-1:0] desc_map_size(input logic [DESC_W-1:0] d);
    return d[MAP_LSB +: MAP_W];
  endfunction

endpackage

// File: rtl/conv_layer_sched_if.sv
// Host/config, weight BIU and MAC-control signals of the layer scheduler.
// master = environment side, slave = scheduler side.
interface conv_layer_sched_if #(
  parameter int LAW = 4
);
  logic           cfg_wen;
  logic [LAW-1:0] cfg_waddr;
  logic [31:0]    cfg_wdata;
  logic           cfg_err;
  logic [LAW:0]   layer_num;
  logic           sched_start;
  logic           sched_busy;
  logic           sched_done;
  logic [LAW-1:0] cur_layer;
  logic           wload_req;
  logic [LAW-1:0] wload_layer;
  logic           wload_ack;
  logic           conv_start;
  logic [7:0]     in_ch;
  logic [7:0]     out_ch;
  logic [15:0]    map_size;
  logic           conv_done;
  logic           proto_err;

  modport master (
    output cfg_wen, cfg_waddr, cfg_wdata, layer_num, sched_start, wload_ack, conv_done,
    input  cfg_err, sched_busy, sched_done, cur_layer, wload_req, wload_layer,
           conv_start, in_ch, out_ch, map_size, proto_err
  );

  modport slave (
    input  cfg_wen, cfg_waddr, cfg_wdata, layer_num, sched_start, wload_ack, conv_done,
    output cfg_err, sched_busy, sched_done, cur_layer, wload_req, wload_layer,
           conv_start, in_ch, out_ch, map_size, proto_err
  );
endinterface

// File: rtl/conv_sched_desc_rf.sv
// Per-layer descriptor table: flop register file with async clear,
// one write port and one combinational read port.
module conv_sched_desc_rf
  import conv_sched_pkg::*;
#(
  parameter int LAYER_MAX = 16,
  parameter int LAW       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [LAW-1:0]    waddr,
  input  logic [DESC_W-1:0] wdata,
  input  logic [LAW-1:0]    raddr,
  output logic [DESC_W-1:0] rdata
);

  logic [DESC_W-1:0] mem [LAYER_MAX];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAYER_MAX; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_layer_sched.sv
// Layer scheduler: walks the descriptor table, requesting a weight preload
// and then a MAC-array conv run for each layer in turn.
module conv_layer_sched
  import conv_sched_pkg::*;
#(
  parameter int LAYER_MAX = 16,
  parameter int LAW       = 4
) (
  input  logic               clk,
  input  logic               rst,
  conv_layer_sched_if.slave  bus
);

  sched_state_t      state, state_nxt;
  logic [LAW-1:0]    cur_layer;
  logic [LAW:0]      n_layers;
  logic              busy;
  logic              cfg_err;
  logic              proto_err;
  logic [CH_W-1:0]   in_ch, out_ch;
  logic [MAP_W-1:0]  map_size;

  logic              addr_ok;
  logic              rf_we;
  logic [LAW-1:0]    rd_idx;
  logic [DESC_W-1:0] rd_desc;
  logic              last_layer;
  logic              start_ok;
  logic              advance;

  assign addr_ok    = ({1'b0, bus.cfg_waddr} < (LAW+1)'(LAYER_MAX));
  assign rf_we      = bus.cfg_wen && (state == IDLE) && addr_ok;
  assign last_layer = ({1'b0, cur_layer} == (n_layers - 1'b1));
  assign start_ok   = (state == IDLE) && bus.sched_start && (bus.layer_num != '0);
  assign advance    = (state == RUN) && bus.conv_done && !last_layer;
  // Read port looks ahead to the layer about to be loaded so params update with the state change
  assign rd_idx     = (state == RUN) ? cur_layer + 1'b1 : '0;

  conv_sched_desc_rf #(
    .LAYER_MAX (LAYER_MAX),
    .LAW       (LAW)
  ) u_desc_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (bus.cfg_waddr),
    .wdata (bus.cfg_wdata),
    .raddr (rd_idx),
    .rdata (rd_desc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sched_start) state_nxt = (bus.layer_num == '0) ? DONE : LOAD;
      LOAD:    if (bus.wload_ack) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (bus.conv_done) state_nxt = last_layer ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_layer <= '0;
      n_layers  <= '0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      proto_err <= 1'b0;
      in_ch     <= '0;
      out_ch    <= '0;
      map_size  <= '0;
    end else begin
      state   <= state_nxt;
      cfg_err <= bus.cfg_wen && ((state != IDLE) || !addr_ok);
      if ((bus.conv_done && (state != RUN)) || (bus.wload_ack && (state != LOAD)))
        proto_err <= 1'b1;
      if (start_ok) begin
        n_layers  <= (bus.layer_num > (LAW+1)'(LAYER_MAX)) ? (LAW+1)'(LAYER_MAX)
                                                           : bus.layer_num;
        cur_layer <= '0;
        busy      <= 1'b1;
      end
      if (start_ok || advance) begin
        in_ch    <= desc_in_ch(rd_desc);
        out_ch   <= desc_out_ch(rd_desc);
        map_size <= desc_map_size(rd_desc);
      end
      if (advance) cur_layer <= cur_layer + 1'b1;
      if (state == DONE) busy <= 1'b0;
    end
  end

  assign bus.wload_req   = (state == LOAD);
  assign bus.conv_start  = (state == START);
  assign bus.sched_done  = (state == DONE);
  assign bus.sched_busy  = busy;
  assign bus.cur_layer   = cur_layer;
  assign bus.wload_layer = cur_layer;
  assign bus.in_ch       = in_ch;
  assign bus.out_ch      = out_ch;
  assign bus.map_size    = map_size;
  assign bus.cfg_err     = cfg_err;
  assign bus.proto_err   = proto_err;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: multi-layer runs, empty run, dropped
// cfg writes, protocol errors, layer-count clamping and mid-run reset.
module tb_conv_layer_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  conv_layer_sched_if #(.LAW(4)) bus ();

  conv_layer_sched #(
    .LAYER_MAX (16),
    .LAW       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle
  int   busy_cyc;
  int   start_cnt;
  int   done_cnt;
  int   req_rise;
  logic req_d;

  always @(negedge clk) begin
    if (bus.sched_busy) busy_cyc <= busy_cyc + 1;
    if (bus.conv_start) start_cnt <= start_cnt + 1;
    if (bus.sched_done) done_cnt <= done_cnt + 1;
    if (bus.wload_req && !req_d) req_rise <= req_rise + 1;
    req_d <= bus.wload_req;
  end

  logic [31:0] exp_tab [16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_desc(input logic [3:0] addr, input logic [31:0] data);
    bus.cfg_wen   = 1'b1;
    bus.cfg_waddr = addr;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_wen   = 1'b0;
    exp_tab[addr] = data;
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL write_cfg_err got=%b want=0", bus.cfg_err); end
  endtask

  task automatic start_sched(input logic [4:0] n);
    bus.layer_num   = n;
    bus.sched_start = 1'b1;
    tick();
    bus.sched_start = 1'b0;
  endtask

  // Entered on the first LOAD cycle of layer idx; leaves on the cycle after conv_done
  task automatic do_layer(input int idx, input bit last_l);
    logic [31:0] e;
    e = exp_tab[idx];
    total++; if (bus.wload_req !== 1'b1) begin bad++; $display("FAIL l%0d wload_req got=%b want=1", idx, bus.wload_req); end
    total++; if (bus.wload_layer !== 4'(idx)) begin bad++; $display("FAIL l%0d wload_layer got=%0d want=%0d", idx, bus.wload_layer, idx); end
    total++; if (bus.cur_layer !== 4'(idx)) begin bad++; $display("FAIL l%0d cur_layer got=%0d want=%0d", idx, bus.cur_layer, idx); end
    total++; if (bus.in_ch !== e[7:0]) begin bad++; $display("FAIL l%0d in_ch@req got=%0d want=%0d", idx, bus.in_ch, e[7:0]); end
    total++; if (bus.out_ch !== e[15:8]) begin bad++; $display("FAIL l%0d out_ch@req got=%0d want=%0d", idx, bus.out_ch, e[15:8]); end
    total++; if (bus.map_size !== e[31:16]) begin bad++; $display("FAIL l%0d map_size@req got=%0d want=%0d", idx, bus.map_size, e[31:16]); end
    total++; if (bus.sched_busy !== 1'b1) begin bad++; $display("FAIL l%0d busy got=%b want=1", idx, bus.sched_busy); end
    tick();
    tick();
    bus.wload_ack = 1'b1;
    total++; if (bus.conv_start !== 1'b0) begin bad++; $display("FAIL l%0d early conv_start got=%b want=0", idx, bus.conv_start); end
    tick();
    bus.wload_ack = 1'b0;
    total++; if (bus.conv_start !== 1'b1) begin bad++; $display("FAIL l%0d conv_start got=%b want=1", idx, bus.conv_start); end
    total++; if (bus.wload_req !== 1'b0) begin bad++; $display("FAIL l%0d req_in_start got=%b want=0", idx, bus.wload_req); end
    total++; if ({bus.map_size, bus.out_ch, bus.in_ch} !== e) begin bad++; $display("FAIL l%0d params@start got=%h want=%h", idx, {bus.map_size, bus.out_ch, bus.in_ch}, e); end
    tick();
    total++; if (bus.conv_start !== 1'b0) begin bad++; $display("FAIL l%0d conv_start_width got=%b want=0", idx, bus.conv_start); end
    repeat (9) tick();
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    if (last_l) begin
      total++; if (bus.sched_done !== 1'b1) begin bad++; $display("FAIL l%0d sched_done got=%b want=1", idx, bus.sched_done); end
      total++; if (bus.wload_req !== 1'b0) begin bad++; $display("FAIL l%0d req_after_last got=%b want=0", idx, bus.wload_req); end
      tick();
      total++; if (bus.sched_done !== 1'b0) begin bad++; $display("FAIL l%0d sched_done_width got=%b want=0", idx, bus.sched_done); end
      total++; if (bus.sched_busy !== 1'b0) begin bad++; $display("FAIL l%0d busy_after_done got=%b want=0", idx, bus.sched_busy); end
      total++; if ({bus.map_size, bus.out_ch, bus.in_ch} !== e) begin bad++; $display("FAIL l%0d params_hold got=%h want=%h", idx, {bus.map_size, bus.out_ch, bus.in_ch}, e); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.cfg_wen = 1'b0; bus.cfg_waddr = '0; bus.cfg_wdata = '0;
    bus.layer_num = '0; bus.sched_start = 1'b0;
    bus.wload_ack = 1'b0; bus.conv_done = 1'b0;
    for (int i = 0; i < 16; i++) exp_tab[i] = '0;
    repeat (2) tick();
    total++; if ({bus.sched_busy, bus.sched_done, bus.wload_req, bus.conv_start} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", {bus.sched_busy, bus.sched_done, bus.wload_req, bus.conv_start}); end
    total++; if ({bus.cfg_err, bus.proto_err} !== 2'b0) begin bad++; $display("FAIL reset_err got=%b want=00", {bus.cfg_err, bus.proto_err}); end
    total++; if ({bus.map_size, bus.out_ch, bus.in_ch, bus.cur_layer} !== 36'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {bus.map_size, bus.out_ch, bus.in_ch, bus.cur_layer}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_three_layers;
    int b0, s0, d0, r0;
    write_desc(4'd0, {16'd1024, 8'd16, 8'd3});
    write_desc(4'd1, {16'd256,  8'd32, 8'd16});
    write_desc(4'd2, {16'd64,   8'd32, 8'd32});
    b0 = busy_cyc; s0 = start_cnt; d0 = done_cnt; r0 = req_rise;
    start_sched(5'd3);
    do_layer(0, 1'b0);
    do_layer(1, 1'b0);
    do_layer(2, 1'b1);
    tick();
    total++; if (busy_cyc - b0 !== 43) begin bad++; $display("FAIL three_busy_span got=%0d want=43", busy_cyc - b0); end
    total++; if (start_cnt - s0 !== 3) begin bad++; $display("FAIL three_conv_starts got=%0d want=3", start_cnt - s0); end
    total++; if (req_rise - r0 !== 3) begin bad++; $display("FAIL three_wload_reqs got=%0d want=3", req_rise - r0); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL three_done_pulses got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_zero_layers;
    int b0, s0, r0;
    b0 = busy_cyc; s0 = start_cnt; r0 = req_rise;
    start_sched(5'd0);
    total++; if (bus.sched_done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", bus.sched_done); end
    total++; if (bus.sched_busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", bus.sched_busy); end
    total++; if (bus.wload_req !== 1'b0) begin bad++; $display("FAIL zero_req got=%b want=0", bus.wload_req); end
    tick();
    total++; if (bus.sched_done !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b want=0", bus.sched_done); end
    tick();
    total++; if ({busy_cyc - b0, start_cnt - s0, req_rise - r0} !== {32'd0, 32'd0, 32'd0}) begin bad++; $display("FAIL zero_activity got busy=%0d starts=%0d reqs=%0d want=0,0,0", busy_cyc - b0, start_cnt - s0, req_rise - r0); end
  endtask

  task automatic test_cfg_drop;
    start_sched(5'd2);
    tick(); tick();
    bus.wload_ack = 1'b1;
    tick();
    bus.wload_ack = 1'b0;
    tick();
    bus.cfg_wen = 1'b1; bus.cfg_waddr = 4'd1; bus.cfg_wdata = 32'h0000_AAAA;
    tick();
    bus.cfg_wen = 1'b0;
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_pulse got=%b want=1", bus.cfg_err); end
    tick();
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_width got=%b want=0", bus.cfg_err); end
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    total++; if (bus.in_ch !== 8'd16) begin bad++; $display("FAIL cfg_drop_entry1 in_ch got=%0d want=16", bus.in_ch); end
    do_layer(1, 1'b1);
    tick();
    start_sched(5'd2);
    do_layer(0, 1'b0);
    do_layer(1, 1'b1);
  endtask

  task automatic test_proto_err;
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    total++; if (bus.proto_err !== 1'b1) begin bad++; $display("FAIL proto_idle_done got=%b want=1", bus.proto_err); end
    total++; if ({bus.sched_busy, bus.wload_req, bus.conv_start, bus.sched_done} !== 4'b0) begin bad++; $display("FAIL proto_idle_state got=%b want=0000", {bus.sched_busy, bus.wload_req, bus.conv_start, bus.sched_done}); end
    bus.layer_num = 5'd1; bus.sched_start = 1'b1;
    tick();
    bus.sched_start = 1'b0;
    bus.wload_ack = 1'b1;
    tick();
    bus.wload_ack = 1'b0;
    total++; if (bus.conv_start !== 1'b1) begin bad++; $display("FAIL proto_same_cycle_ack conv_start got=%b want=1", bus.conv_start); end
    tick();
    bus.wload_ack = 1'b1;
    tick();
    bus.wload_ack = 1'b0;
    total++; if ({bus.sched_busy, bus.wload_req, bus.conv_start} !== 3'b100) begin bad++; $display("FAIL proto_run_state got=%b want=100", {bus.sched_busy, bus.wload_req, bus.conv_start}); end
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    total++; if (bus.sched_done !== 1'b1) begin bad++; $display("FAIL proto_done got=%b want=1", bus.sched_done); end
    tick(); tick();
    total++; if (bus.proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b want=1", bus.proto_err); end
  endtask

  task automatic test_layer_cap;
    int s0;
    s0 = start_cnt;
    start_sched(5'd20);
    for (int i = 0; i < 16; i++) do_layer(i, i == 15);
    tick();
    total++; if (start_cnt - s0 !== 16) begin bad++; $display("FAIL cap_layers got=%0d want=16", start_cnt - s0); end
    total++; if (bus.cur_layer !== 4'd15) begin bad++; $display("FAIL cap_last_layer got=%0d want=15", bus.cur_layer); end
  endtask

  task automatic test_reset_midrun;
    start_sched(5'd2);
    do_layer(0, 1'b0);
    total++; if ({bus.wload_req, bus.cur_layer} !== {1'b1, 4'd1}) begin bad++; $display("FAIL midrun_pre got=%b want=10001", {bus.wload_req, bus.cur_layer}); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (bus.wload_req !== 1'b0) begin bad++; $display("FAIL midrun_req got=%b want=0", bus.wload_req); end
    total++; if (bus.sched_busy !== 1'b0) begin bad++; $display("FAIL midrun_busy got=%b want=0", bus.sched_busy); end
    total++; if (bus.cur_layer !== 4'd0) begin bad++; $display("FAIL midrun_cur_layer got=%0d want=0", bus.cur_layer); end
    total++; if (bus.proto_err !== 1'b0) begin bad++; $display("FAIL midrun_proto got=%b want=0", bus.proto_err); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_tab[i] = '0;
    tick();
    start_sched(5'd1);
    do_layer(0, 1'b1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    busy_cyc = 0; start_cnt = 0; done_cnt = 0; req_rise = 0; req_d = 1'b0;
    test_reset();
    test_three_layers();
    test_zero_layers();
    test_cfg_drop();
    test_proto_err();
    test_layer_cap();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
Layer-level scheduler that sequences the MAC array across a multi-layer network.
- Holds a small descriptor table of per-layer conv parameters, written by the host.
- On start, it walks the table. For each layer it requests a weight preload from the weight BIU, then pulses conv_start with that layer's in_ch/out_ch/map_size and waits for conv_done.
- Sits between the host/config bus, the weight BIU and the MAC array control port.

Parameters:
LAYER_MAX, 16, depth of the descriptor table (number of layers supported).
LAW, 4, descriptor address width, equal to clog2(LAYER_MAX).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
cfg_wen  input  1  descriptor write strobe.
cfg_waddr  input  LAW  descriptor index to write.
cfg_wdata  input  32  descriptor {map_size[31:16], out_ch[15:8], in_ch[7:0]}.
cfg_err  output  1  one-cycle pulse when a cfg write is dropped.
layer_num  input  LAW+1  number of layers to run; sampled at sched_start.
sched_start  input  1  start pulse.
sched_busy  output  1  high from the accepted start until sched_done.
sched_done  output  1  one-cycle pulse when all layers are complete.
cur_layer  output  LAW  index of the layer being processed.
wload_req  output  1  weight preload request for cur_layer (level).
wload_layer  output  LAW  layer index accompanying wload_req (equals cur_layer).
wload_ack  input  1  weight preload complete.
conv_start  output  1  one-cycle pulse to the MAC array.
in_ch  output  8  registered in_ch of cur_layer.
out_ch  output  8  registered out_ch of cur_layer.
map_size  output  16  registered map_size of cur_layer.
conv_done  input  1  MAC array layer completion pulse.
proto_err  output  1  sticky; set on conv_done outside RUN or wload_ack outside LOAD.

Behaviour:
Reset (async, rst=1):
- State goes to IDLE and the descriptor table clears to 0.
- All outputs go to 0, including proto_err.
Descriptor writes:
- Written on cfg_wen only in IDLE.
- A cfg_wen while busy is dropped and pulses cfg_err in the next cycle.
- A cfg_waddr >= LAYER_MAX is dropped and pulses cfg_err.
FSM states are IDLE, LOAD, START, RUN, DONE.
IDLE:
- sched_start with layer_num==0 goes to DONE. sched_done is high the next cycle and sched_busy stays 0.
- sched_start with layer_num>0:
  - Latch n = min(layer_num, LAYER_MAX) and set cur_layer=0.
  - Load in_ch/out_ch/map_size from entry 0.
  - Go to LOAD; sched_busy=1 from the next cycle.
LOAD:
- wload_req=1 and wload_layer=cur_layer.
- wload_ack goes to START.
- An ack in the same cycle LOAD is first entered counts.
START:
- conv_start=1 for exactly one cycle; in_ch/out_ch/map_size are already stable.
- Always goes to RUN.
RUN:
- Waits for conv_done.
- If cur_layer==n-1, go to DONE.
- Otherwise cur_layer++, reload the parameter registers from the new entry and go to LOAD. The new values are visible the same cycle wload_req re-asserts.
DONE:
- sched_done=1 for one cycle, sched_busy drops, go to IDLE.
Latency:
- sched_start at cycle T gives wload_req at T+1.
- wload_ack at cycle A gives conv_start at A+1.
- conv_done at cycle D gives wload_req (next layer) at D+1, or sched_done at D+1 for the last layer.
Ignored and error inputs:
- sched_start while busy is ignored.
- conv_done outside RUN or wload_ack outside LOAD is ignored and sets proto_err. proto_err is cleared only by rst.
Reset mid-operation aborts immediately: all outputs go to 0, including a wload_req or conv_start in flight.
Parameter outputs hold their last values after DONE.

Decomposition:
Shared package conv_sched_pkg:
- state encoding localparams (IDLE=0 … DONE=4);
- descriptor field offsets/widths (IN_CH_LSB=0, OUT_CH_LSB=8, MAP_LSB=16).
One sub-module, conv_sched_desc_rf:
- LAYER_MAX x 32 flop register file;
- async-clear write port gated by the IDLE qualifier;
- combinational read port indexed by the next cur_layer.

Test Plan:
Write 3 descriptors (in/out/map = 3/16/1024, 16/32/256, 32/32/64), layer_num=3, wload_ack 2 cycles after each req, conv_done 10 cycles after each conv_start -> 3 wload_req/conv_start pairs with matching params, cur_layer 0,1,2, one sched_done, busy span = 3*(1+2+1+10)+1 cycles.
layer_num=0 start -> sched_done the next cycle, no wload_req, no conv_start, busy stays 0.
cfg_wen during RUN to entry 1 -> cfg_err pulse, entry 1 unchanged on readback via the next run's in_ch.
conv_done pulsed in IDLE and wload_ack in RUN -> proto_err=1 and stays 1, FSM state unchanged.
layer_num=20 with LAYER_MAX=16 -> exactly 16 layers run, last cur_layer=15.
rst asserted during LOAD with wload_req high -> wload_req, sched_busy and cur_layer go to 0 asynchronously; a new start after rst deassert runs layer 0 with zeroed params.
